// File: rtl/issue_arbiter.sv
// Round-robin issue arbiter: picks one ready reservation-station entry per
// cycle starting from a rotating priority pointer, and holds the registered
// grant stable under a valid/ready handshake until the functional unit
// accepts it or a flush withdraws it.
module issue_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               flush,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               issue_fire
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] oh_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [NUM_REQ-1:0] remain;
  logic [IDX_W-1:0]   ptr_inc;

  // First set bit of mask scanning upward from p with wrap; zero if mask is empty.
  // NUM_REQ is a power of two, so IDX_W-bit addition wraps modulo NUM_REQ.
  function automatic logic [NUM_REQ-1:0] sel_oh(input logic [NUM_REQ-1:0] mask,
                                                input logic [IDX_W-1:0]   p);
    logic [NUM_REQ-1:0] oh;
    logic               found;
    logic [IDX_W-1:0]   pos;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = p + i[IDX_W-1:0];
      if (!found && mask[pos]) begin
        oh[pos] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  // Binary encoding of a one-hot (or all-zero) vector.
  function automatic logic [IDX_W-1:0] enc(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = idx | k[IDX_W-1:0];
    end
    return idx;
  endfunction

  assign issue_valid = (state == HOLD);
  assign issue_fire  = issue_valid & issue_ready & ~flush;
  assign ptr_inc     = grant_idx + 1'b1;
  assign remain      = req & ~grant_oh;

  // Next-state, pointer and grant selection; flush dominates a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    oh_nxt    = grant_oh;
    idx_nxt   = grant_idx;
    case (state)
      IDLE: begin
        if (!flush && (req != '0)) begin
          oh_nxt    = sel_oh(req, ptr);
          idx_nxt   = enc(oh_nxt);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          oh_nxt    = '0;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else if (issue_ready) begin
          ptr_nxt = ptr_inc;
          if (remain != '0) begin
            oh_nxt  = sel_oh(remain, ptr_inc);
            idx_nxt = enc(oh_nxt);
          end else begin
            oh_nxt    = '0;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        oh_nxt    = '0;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer and registered grant outputs with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_oh  <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_oh  <= oh_nxt;
      grant_idx <= idx_nxt;
    end
  end

endmodule

// File: doc/issue_arbiter.md
# issue_arbiter

Round-robin issue arbiter that shares one functional-unit issue port between `NUM_REQ` reservation-station entries. Each cycle it picks one ready entry, starting from a rotating priority pointer. It presents the winner as both a one-hot grant and a binary index, and holds that grant stable under a valid/ready handshake until the functional unit accepts it. It sits between the reservation-station wakeup logic and the functional-unit input stage of the out-of-order core.

## Interface
Parameters:
- `NUM_REQ`, default 8: number of requesting entries; must be a power of two and at least 2.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the encoded index. Derived; never overridden.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `req`  in  `NUM_REQ`: bit k set means entry k is ready to issue.
- `flush`  in  1: squash the outstanding grant (branch mispredict or exception).
- `issue_ready`  in  1: functional unit can accept an issue this cycle.
- `issue_valid`  out  1: a grant is being presented. Registered.
- `grant_oh`  out  `NUM_REQ`: one-hot grant, all zero when `issue_valid`=0. Registered.
- `grant_idx`  out  `IDX_W`: binary encoding of `grant_oh`, 0 when idle. Registered.
- `issue_fire`  out  1: equals `issue_valid & issue_ready & ~flush`. Combinational; tells the reservation station to deallocate entry `grant_idx`.

## Operation
- **State machine:**
  - IDLE: `issue_valid`=0.
  - HOLD: `issue_valid`=1; `grant_oh` and `grant_idx` are frozen.
- **Internal state:** round-robin pointer `ptr`, `IDX_W` bits.
- **Selection function** `sel(mask, p)`: the first set bit of `mask` scanning p, p+1, …, NUM_REQ-1, 0, …, p-1 (wraps modulo NUM_REQ). Result is one-hot plus the matching index; zero if `mask`=0.
- **IDLE transitions:**
  - `flush`=1: stay in IDLE.
  - `req`≠0: load `sel(req, ptr)` and go to HOLD.
  - Otherwise stay in IDLE.
- **HOLD transitions:**
  - `flush`=1: go to IDLE and clear grant outputs. `ptr` is unchanged. No fire.
  - `issue_fire`=1: set `ptr` ← (`grant_idx`+1) mod NUM_REQ. Let m = `req & ~grant_oh`.
    - m≠0: load `sel(m, ` new `ptr)` and stay in HOLD (back-to-back issue).
    - m=0: go to IDLE.
  - Otherwise (backpressure): hold all outputs. Changes on `req`, including the granted bit dropping, are ignored; only `flush` withdraws a grant.
- **Invariants:**
  - `grant_oh` has exactly one bit set in HOLD and zero bits set in IDLE.
  - `grant_idx` always equals the encoding of `grant_oh`.
  - `ptr` changes only on `issue_fire`.
- **Fairness:** with all requests held high and `issue_ready`=1, every entry is granted exactly once per NUM_REQ fires.

## Timing
- **Reset:** asynchronous assertion sets state=IDLE, `ptr`=0, `issue_valid`=0, `grant_oh`=0, `grant_idx`=0, effective immediately, including mid-HOLD. Deassertion is sampled at the next rising edge.
- **Request-to-grant latency:** a request seen in IDLE at edge t produces `issue_valid` after edge t (visible in cycle t+1).
- **Throughput:** one issue per cycle when `issue_ready` is held high and requests remain.
- **Handshake:** occurs on any edge where `issue_valid & issue_ready & ~flush`. `grant_oh` and `grant_idx` must not change while `issue_valid`=1 and no handshake or flush occurs.
- **Same-cycle events:** `flush` and `issue_ready` in the same cycle means `flush` wins: no fire, `ptr` held, state returns to IDLE.
- **`issue_ready` in IDLE:** ignored.

## Test plan
- **Reset:** assert `rst_n`=0 mid-HOLD with `grant_idx`=5 → `issue_valid`, `grant_oh`, and `grant_idx` go to 0 immediately, without waiting for a clock edge. After release, `req`=8'b00001000 grants idx 3, confirming `ptr`=0.
- **Single request:** `req`=8'b00000100, `issue_ready`=1 → one cycle later `issue_valid`=1, `grant_oh`=8'b00000100, `grant_idx`=2, `issue_fire`=1. Drop `req` → IDLE next cycle.
- **Round robin:** `req`=8'hFF held, `issue_ready`=1 → `grant_idx` sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles with `issue_valid` continuously high.
- **Backpressure:** `req`=8'b10010000, `issue_ready`=0 for 5 cycles, with `req` changed to 8'b10000000 during the stall → `grant_idx` stays 4 and `grant_oh` stays 8'b00010000. Raise `issue_ready` → fire idx 4, then idx 7 on the next cycle.
- **Wrap-around:** fire idx 5 (so `ptr`=6), then `req`=8'b00000011 → grant idx 0, then idx 1.
- **Flush:** in HOLD on idx 2 with `issue_ready`=1 and `flush`=1 → `issue_fire`=0, IDLE next cycle, `ptr` unchanged. `req`=8'b00001100 then regrants idx 2.
